// File: rtl/rng_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : rng_fetch_if
// Description : Seed/generator/consumer bundle for the rng_fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
interface rng_fetch_if;
    logic [127:0] seed_i;
    logic [127:0] poly_i;
    logic         reseed_i;
    logic         gen_load_o;
    logic [127:0] gen_seed_o;
    logic [127:0] gen_poly_o;
    logic [127:0] gen_entropy_i;
    logic         gen_valid_i;
    logic [31:0]  rand_data_o;
    logic         rand_valid_o;
    logic         rand_ready_i;
    logic         stuck_o;

    modport master (
        input  seed_i, poly_i, reseed_i, gen_entropy_i, gen_valid_i, rand_ready_i,
        output gen_load_o, gen_seed_o, gen_poly_o, rand_data_o, rand_valid_o, stuck_o
    );

    modport slave (
        output seed_i, poly_i, reseed_i, gen_entropy_i, gen_valid_i, rand_ready_i,
        input  gen_load_o, gen_seed_o, gen_poly_o, rand_data_o, rand_valid_o, stuck_o
    );
endinterface
`default_nettype wire

// File: rtl/rng_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rng_fetch
// Description : Seeds a generator, captures its state after a warm-up count,
//               health-checks it and drains it as four 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module rng_fetch #(
    parameter int REFRESH_CYCLES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    rng_fetch_if.master bus
);
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_warm  = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_error = 3'd4;

    localparam logic [7:0] c_last_cnt = 8'(REFRESH_CYCLES - 1);

    logic [2:0]   r_state, w_state_nxt;
    logic [7:0]   r_cnt, w_cnt_nxt;
    logic [1:0]   r_idx, w_idx_nxt;
    logic [127:0] r_buf, w_buf_nxt;
    logic [127:0] r_prev, w_prev_nxt;
    logic         r_prev_vld, w_prev_vld_nxt;
    logic [127:0] r_seed, w_seed_nxt;
    logic         r_load, w_load_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_stuck, w_stuck_nxt;
    logic [31:0]  r_data, w_data_nxt;

    logic w_reseed;
    logic w_capture;
    logic w_health_bad;
    logic w_xfer;

    assign w_reseed     = bus.reseed_i && ((r_state == c_st_warm) ||
                                           (r_state == c_st_drain) ||
                                           (r_state == c_st_error));
    assign w_capture    = (r_state == c_st_warm) && bus.gen_valid_i && (r_cnt == c_last_cnt);
    assign w_health_bad = (bus.gen_entropy_i == '0) ||
                          (r_prev_vld && (bus.gen_entropy_i == r_prev));
    assign w_xfer       = (r_state == c_st_drain) && r_valid && bus.rand_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reseed outranks both a capture and a transfer in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  w_state_nxt = c_st_load;
            c_st_load:  w_state_nxt = c_st_warm;
            c_st_warm: begin
                if (w_reseed) begin
                    w_state_nxt = c_st_load;
                end else if (w_capture) begin
                    w_state_nxt = w_health_bad ? c_st_error : c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_reseed) begin
                    w_state_nxt = c_st_load;
                end else if (w_xfer && (r_idx == 2'd3)) begin
                    w_state_nxt = c_st_warm;
                end
            end
            c_st_error: begin
                if (w_reseed) begin
                    w_state_nxt = c_st_load;
                end
            end
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_buf_nxt      = r_buf;
        w_prev_nxt     = r_prev;
        w_prev_vld_nxt = r_prev_vld;
        w_seed_nxt     = r_seed;

        if (w_state_nxt == c_st_load) begin
            w_cnt_nxt      = '0;
            w_idx_nxt      = '0;
            w_buf_nxt      = '0;
            w_prev_nxt     = '0;
            w_prev_vld_nxt = 1'b0;
            w_seed_nxt     = bus.seed_i;
        end else if ((r_state == c_st_warm) && bus.gen_valid_i) begin
            if (w_capture) begin
                w_buf_nxt = bus.gen_entropy_i;
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_health_bad) begin
                    w_prev_nxt     = bus.gen_entropy_i;
                    w_prev_vld_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
        end else if (w_xfer) begin
            // Two-bit index wraps back to word 0 after the last word.
            w_idx_nxt = r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                w_cnt_nxt = '0;
            end
        end

        w_load_nxt  = (w_state_nxt == c_st_load);
        w_valid_nxt = (w_state_nxt == c_st_drain);
        w_stuck_nxt = (w_state_nxt == c_st_error);
        w_data_nxt  = w_valid_nxt ? w_buf_nxt[{w_idx_nxt, 5'd0} +: 32] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_buf      <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_seed     <= '0;
            r_load     <= 1'b0;
            r_valid    <= 1'b0;
            r_stuck    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_buf      <= w_buf_nxt;
            r_prev     <= w_prev_nxt;
            r_prev_vld <= w_prev_vld_nxt;
            r_seed     <= w_seed_nxt;
            r_load     <= w_load_nxt;
            r_valid    <= w_valid_nxt;
            r_stuck    <= w_stuck_nxt;
            r_data     <= w_data_nxt;
        end
    end

    assign bus.gen_load_o   = r_load;
    assign bus.gen_seed_o   = r_seed;
    assign bus.gen_poly_o   = bus.poly_i;
    assign bus.rand_data_o  = r_data;
    assign bus.rand_valid_o = r_valid;
    assign bus.stuck_o      = r_stuck;
endmodule
`default_nettype wire

// File: tb/tb_rng_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rng_fetch
// Description : Directed self-checking bench for rng_fetch with an LFSR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_fetch;
    localparam int R = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rng_fetch_if bus ();

    rng_fetch #(.REFRESH_CYCLES(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] gst;
    logic [127:0] const_val;
    logic         const_mode;
    logic         toggle;
    logic         phase;
    int           adv_cnt, adv_prev, cyc, first_adv, loads, valids;
    logic [127:0] exp_v;
    logic [31:0]  cw [4];

    function automatic logic [127:0] lfsr_step(logic [127:0] s, logic [127:0] p);
        return {s[126:0], ^(s & p)};
    endfunction

    function automatic logic [127:0] lfsr_n(logic [127:0] s, logic [127:0] p, int n);
        logic [127:0] v;
        v = s;
        for (int k = 0; k < n; k++) v = lfsr_step(v, p);
        return v;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards the generator model reacts to what the DUT drove before the edge.
    task automatic tick();
        logic         ld;
        logic [127:0] sd;
        ld       = bus.gen_load_o;
        sd       = bus.gen_seed_o;
        adv_prev = adv_cnt;
        @(posedge clk);
        #1;
        cyc++;
        if (ld) begin
            gst             = sd;
            adv_cnt         = 0;
            bus.gen_valid_i = 1'b0;
            phase           = 1'b1;
            first_adv       = -1;
        end else if (!toggle || phase) begin
            gst             = lfsr_step(gst, bus.poly_i);
            adv_cnt++;
            bus.gen_valid_i = 1'b1;
            phase           = ~phase;
            if (first_adv < 0) first_adv = cyc;
        end else begin
            bus.gen_valid_i = 1'b0;
            phase           = ~phase;
        end
        bus.gen_entropy_i = const_mode ? const_val : gst;
        if (bus.gen_load_o)   loads++;
        if (bus.rand_valid_o) valids++;
    endtask

    task automatic wait_valid(string tag, int budget);
        int n;
        n = 0;
        while (!bus.rand_valid_o && n < budget) begin
            tick();
            n++;
        end
        chk(tag, bus.rand_valid_o, 1'b1);
    endtask

    task automatic wait_stuck(string tag, int budget);
        int n;
        n = 0;
        while (!bus.stuck_o && n < budget) begin
            tick();
            n++;
        end
        chk(tag, bus.stuck_o, 1'b1);
    endtask

    task automatic do_reset(logic [127:0] seed, logic [127:0] poly, logic cm, logic tg);
        rst_n             = 1'b0;
        bus.seed_i        = seed;
        bus.poly_i        = poly;
        bus.reseed_i      = 1'b0;
        bus.rand_ready_i  = 1'b1;
        bus.gen_valid_i   = 1'b0;
        const_mode        = cm;
        toggle            = tg;
        gst               = '0;
        bus.gen_entropy_i = cm ? const_val : '0;
        adv_cnt           = 0;
        phase             = 1'b1;
        first_adv         = -1;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        loads  = 0;
        valids = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc       = 0;
        const_val = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        cw        = '{32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};

        // Nominal LFSR run: reset values, load pulse, warm-up length, word order.
        do_reset(128'h1, 128'h87, 1'b0, 1'b0);
        chk("rst_load",  bus.gen_load_o,   1'b0);
        chk("rst_seed",  bus.gen_seed_o,   128'h0);
        chk("rst_valid", bus.rand_valid_o, 1'b0);
        chk("rst_data",  bus.rand_data_o,  32'h0);
        chk("rst_stuck", bus.stuck_o,      1'b0);
        tick();
        chk("load_pulse", bus.gen_load_o, 1'b1);
        chk("load_seed",  bus.gen_seed_o, 128'h1);
        chk("poly_pass",  bus.gen_poly_o, 128'h87);
        tick();
        chk("load_once", bus.gen_load_o, 1'b0);
        wait_valid("t1_valid", 400);
        chk("t1_adv",   adv_prev, R);
        chk("t1_loads", loads,    1);
        exp_v = lfsr_n(128'h1, 128'h87, R);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_w%0d", i), bus.rand_data_o, exp_v[32*i +: 32]);
            chk($sformatf("t1_v%0d", i), bus.rand_valid_o, 1'b1);
            tick();
        end
        chk("t1_valid_drop", bus.rand_valid_o, 1'b0);

        // Backpressure on word 1.
        do_reset(128'h1, 128'h87, 1'b0, 1'b0);
        bus.rand_ready_i = 1'b0;
        wait_valid("t2_valid", 400);
        chk("t2_w0", bus.rand_data_o, exp_v[31:0]);
        bus.rand_ready_i = 1'b1;
        tick();
        bus.rand_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t2_hold_d%0d", k), bus.rand_data_o, exp_v[63:32]);
            chk($sformatf("t2_hold_v%0d", k), bus.rand_valid_o, 1'b1);
            tick();
        end
        bus.rand_ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t2_w%0d", i), bus.rand_data_o, exp_v[32*i +: 32]);
            tick();
        end
        chk("t2_valid_drop", bus.rand_valid_o, 1'b0);

        // Generator advancing every other cycle.
        do_reset(128'h1, 128'h87, 1'b0, 1'b1);
        wait_valid("t3_valid", 800);
        chk("t3_adv",    adv_prev,        R);
        chk("t3_clocks", cyc - first_adv, 2 * R - 1);
        chk("t3_w0",     bus.rand_data_o, exp_v[31:0]);

        // Zero taps drive the capture to all-zero.
        do_reset(128'h1, 128'h0, 1'b0, 1'b0);
        wait_stuck("t4_stuck", 400);
        chk("t4_adv",    adv_prev, R);
        chk("t4_novalid", valids,  0);
        repeat (5) tick();
        chk("t4_stuck_hold", bus.stuck_o,      1'b1);
        chk("t4_valid_hold", bus.rand_valid_o, 1'b0);
        loads        = 0;
        bus.reseed_i = 1'b1;
        tick();
        bus.reseed_i = 1'b0;
        chk("t4_stuck_clr", bus.stuck_o,    1'b0);
        chk("t4_load",      bus.gen_load_o, 1'b1);
        repeat (5) tick();
        chk("t4_one_load", loads, 1);

        // Constant generator: first capture drains, repeat capture trips the check.
        do_reset(128'h1, 128'h87, 1'b1, 1'b0);
        wait_valid("t5_valid", 400);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_w%0d", i), bus.rand_data_o, cw[i]);
            tick();
        end
        chk("t5_valid_drop", bus.rand_valid_o, 1'b0);
        wait_stuck("t5_stuck", 400);
        chk("t5_words", valids,           4);
        chk("t5_novalid", bus.rand_valid_o, 1'b0);

        // Reseed on the last-word transfer.
        do_reset(128'h1, 128'h87, 1'b0, 1'b0);
        wait_valid("t6_valid", 400);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_w3", bus.rand_data_o, exp_v[127:96]);
        bus.seed_i   = 128'h5;
        bus.reseed_i = 1'b1;
        tick();
        bus.reseed_i = 1'b0;
        valids       = 0;
        chk("t6_load",  bus.gen_load_o,   1'b1);
        chk("t6_valid", bus.rand_valid_o, 1'b0);
        chk("t6_seed",  bus.gen_seed_o,   128'h5);
        wait_valid("t6_rewarm", 400);
        chk("t6_adv",    adv_prev, R);
        chk("t6_valids", valids,   1);
        exp_v = lfsr_n(128'h5, 128'h87, R);
        chk("t6_w0", bus.rand_data_o, exp_v[31:0]);

        // Asynchronous reset mid-drain.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_valid", bus.rand_valid_o, 1'b0);
        chk("t7_data",  bus.rand_data_o,  32'h0);
        chk("t7_seed",  bus.gen_seed_o,   128'h0);
        chk("t7_load",  bus.gen_load_o,   1'b0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        valids = 0;
        tick();
        chk("t7_reload", bus.gen_load_o, 1'b1);
        repeat (20) tick();
        chk("t7_nodata", valids, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
